// File: rtl/video_pkg.sv
// Shared video constants and types for the capture path.
// Used by the decimator and the frame-buffer writer.
package video_pkg;

    localparam int DATA_W   = 12;
    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;

    localparam int X_W = $clog2(H_ACTIVE);
    localparam int Y_W = $clog2(V_ACTIVE);

    typedef logic [DATA_W-1:0] pixel_t;

endpackage

// File: rtl/pixel_pos_counter.sv
// Raster position tracker: x advances per accepted pixel and wraps at line end.
// y advances on each x wrap and wraps at frame end.
module pixel_pos_counter
    import video_pkg::*;
#(
    parameter int H_ACTIVE = video_pkg::H_ACTIVE,
    parameter int V_ACTIVE = video_pkg::V_ACTIVE,
    parameter int X_W      = $clog2(H_ACTIVE),
    parameter int Y_W      = $clog2(V_ACTIVE)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           inc,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y
);

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x <= '0;
            y <= '0;
        end else if (inc) begin
            if (x == X_W'(H_ACTIVE - 1)) begin
                x <= '0;
                y <= (y == Y_W'(V_ACTIVE - 1)) ? '0 : y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end

endmodule

// File: rtl/downscaling.sv
// Streaming 2:1 decimator: drains a standard-mode FIFO and keeps only pixels
// at even column and even row, emitting a registered data/valid strobe.
module downscaling
    import video_pkg::*;
#(
    parameter int DATA_W   = video_pkg::DATA_W,
    parameter int H_ACTIVE = video_pkg::H_ACTIVE,
    parameter int V_ACTIVE = video_pkg::V_ACTIVE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] fifo_dout,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    output logic [DATA_W-1:0] scaled_data,
    output logic              scaled_valid
);

    localparam int X_W = $clog2(H_ACTIVE);
    localparam int Y_W = $clog2(V_ACTIVE);

    logic           rd_pending;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic           keep;

    assign fifo_rd_en = rst & ~fifo_empty;

    // Non-FWFT FIFO: data for an accepted read appears one cycle later.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_pending <= 1'b0;
        end else begin
            rd_pending <= fifo_rd_en & ~fifo_empty;
        end
    end

    // Counters hold the position of the pixel currently on fifo_dout.
    pixel_pos_counter #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE)
    ) u_pos (
        .clk (clk),
        .rst (rst),
        .inc (rd_pending),
        .x   (x),
        .y   (y)
    );

    assign keep = rd_pending & ~x[0] & ~y[0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scaled_valid <= 1'b0;
            scaled_data  <= '0;
        end else begin
            scaled_valid <= keep;
            if (keep) begin
                scaled_data <= fifo_dout;
            end
        end
    end

endmodule

// File: tb/tb_downscaling.sv
// Directed bench for downscaling: full-size instance for line/gap/reset cases,
// small 4x2 instance for the frame wrap.
module tb_downscaling;

    logic        clk = 1'b0;
    logic        rst;
    logic        fifo_clr;

    logic [11:0] fifo_dout  = '0;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [11:0] scaled_data;
    logic        scaled_valid;

    logic [11:0] fifo_dout2 = '0;
    logic        fifo_empty2;
    logic        fifo_rd_en2;
    logic [11:0] scaled_data2;
    logic        scaled_valid2;

    int next_val  = 0;
    int next_val2 = 0;
    int cyc_cnt   = 0;
    int rd_viol   = 0;
    int obs_q[$];
    int obs_t[$];
    int obs2_q[$];

    int vec = 0;
    int err = 0;

    always #20 clk = ~clk;

    downscaling dut (
        .clk          (clk),
        .rst          (rst),
        .fifo_dout    (fifo_dout),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .scaled_data  (scaled_data),
        .scaled_valid (scaled_valid)
    );

    downscaling #(
        .DATA_W   (12),
        .H_ACTIVE (4),
        .V_ACTIVE (2)
    ) dut_small (
        .clk          (clk),
        .rst          (rst),
        .fifo_dout    (fifo_dout2),
        .fifo_empty   (fifo_empty2),
        .fifo_rd_en   (fifo_rd_en2),
        .scaled_data  (scaled_data2),
        .scaled_valid (scaled_valid2)
    );

    // FIFO models: latency 1, read data = read index since last clear.
    always @(posedge clk) begin
        cyc_cnt <= cyc_cnt + 1;
        if (fifo_clr) begin
            next_val   <= 0;
            next_val2  <= 0;
            fifo_dout  <= '0;
            fifo_dout2 <= '0;
        end else begin
            if (fifo_rd_en && !fifo_empty) begin
                fifo_dout <= 12'(next_val);
                next_val  <= next_val + 1;
            end
            if (fifo_rd_en2 && !fifo_empty2) begin
                fifo_dout2 <= 12'(next_val2);
                next_val2  <= next_val2 + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (scaled_valid) begin
            obs_q.push_back(int'(scaled_data));
            obs_t.push_back(cyc_cnt);
        end
        if (scaled_valid2) begin
            obs2_q.push_back(int'(scaled_data2));
        end
        if ((fifo_rd_en && fifo_empty) || (fifo_rd_en2 && fifo_empty2)) begin
            rd_viol++;
        end
    end

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        vec++;
        assert (observed === expected) else begin
            err++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic hold_reset();
        rst        = 1'b0;
        fifo_clr   = 1'b1;
        fifo_empty = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        int base;
        int n;
        int first_rd;
        int g;
        int exp_v;

        rst         = 1'b0;
        fifo_clr    = 1'b1;
        fifo_empty  = 1'b0;
        fifo_empty2 = 1'b1;
        tick();
        tick();

        // Reset held with data available: no reads, outputs cleared.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
            check("rst_valid", 32'(scaled_valid), 32'd0);
            check("rst_data", 32'(scaled_data), 32'd0);
            check("rst_valid_small", 32'(scaled_valid2), 32'd0);
        end
        tick();

        // Continuous stream: lines 0, 1 and 2.
        base     = obs_q.size();
        fifo_clr = 1'b0;
        rst      = 1'b1;
        first_rd = cyc_cnt;
        g = 0;
        while (next_val < 1920 && g < 5000) begin
            tick();
            g++;
        end
        fifo_empty = 1'b1;
        check("stream_reads", 32'(next_val), 32'd1920);
        repeat (4) tick();

        n = obs_q.size() - base;
        check("stream_count", 32'(n), 32'd640);
        for (int i = 0; i < 640 && i < n; i++) begin
            exp_v = (i < 320) ? 2 * i : 1280 + 2 * (i - 320);
            check("stream_value", 32'(obs_q[base + i]), 32'(exp_v));
        end
        if (n > 0) begin
            check("first_latency", 32'(obs_t[base] - first_rd), 32'd2);
        end
        for (int i = 1; i < 320 && i < n; i++) begin
            check("line0_spacing", 32'(obs_t[base + i] - obs_t[base + i - 1]), 32'd2);
        end
        if (n > 320) begin
            check("odd_line_gap", 32'(obs_t[base + 320] - obs_t[base + 319]), 32'd642);
        end

        // Line 0 with random FIFO-empty gaps.
        hold_reset();
        base     = obs_q.size();
        fifo_clr = 1'b0;
        rst      = 1'b1;
        g = 0;
        while (next_val < 640 && g < 10000) begin
            fifo_empty = 1'($urandom_range(0, 1));
            tick();
            g++;
        end
        fifo_empty = 1'b1;
        check("gap_reads", 32'(next_val), 32'd640);
        repeat (4) tick();
        n = obs_q.size() - base;
        check("gap_count", 32'(n), 32'd320);
        for (int i = 0; i < 320 && i < n; i++) begin
            check("gap_value", 32'(obs_q[base + i]), 32'(2 * i));
        end

        // Reset while pixel 101 sits on the FIFO output.
        hold_reset();
        base     = obs_q.size();
        fifo_clr = 1'b0;
        rst      = 1'b1;
        g = 0;
        while (next_val < 102 && g < 1000) begin
            tick();
            g++;
        end
        fifo_empty = 1'b1;
        tick();
        n = obs_q.size() - base;
        check("pre_reset_count", 32'(n), 32'd51);
        if (n > 0) begin
            check("pre_reset_last", 32'(obs_q[base + n - 1]), 32'd100);
        end
        rst = 1'b0;
        #1;
        check("midrst_valid", 32'(scaled_valid), 32'd0);
        check("midrst_data", 32'(scaled_data), 32'd0);
        check("midrst_rd_en", 32'(fifo_rd_en), 32'd0);
        hold_reset();
        base     = obs_q.size();
        fifo_clr = 1'b0;
        rst      = 1'b1;
        g = 0;
        while (next_val < 40 && g < 1000) begin
            tick();
            g++;
        end
        fifo_empty = 1'b1;
        repeat (4) tick();
        n = obs_q.size() - base;
        check("post_reset_count", 32'(n), 32'd20);
        for (int i = 0; i < 20 && i < n; i++) begin
            check("post_reset_value", 32'(obs_q[base + i]), 32'(2 * i));
        end

        // Small 4x2 frame: 16 values span two frames.
        fifo_empty2 = 1'b0;
        g = 0;
        while (next_val2 < 16 && g < 1000) begin
            tick();
            g++;
        end
        fifo_empty2 = 1'b1;
        repeat (4) tick();
        check("wrap_count", 32'(obs2_q.size()), 32'd4);
        for (int i = 0; i < 4 && i < obs2_q.size(); i++) begin
            exp_v = (i < 2) ? 2 * i : 8 + 2 * (i - 2);
            check("wrap_value", 32'(obs2_q[i]), 32'(exp_v));
        end

        check("rd_en_while_empty", 32'(rd_viol), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
